// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, the MULT/DIV result waits (valid/ready) and forces a pipe stall when starved.
// Writes land one cycle after grant; pending-destination scoreboard gates issue. RF_ARB_WAW_CHECK_EN builds the sticky waw_err check.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT      = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     llu_valid,
  input  logic [ADDR_W-1:0]        llu_reg,
  input  logic [DATA_W-1:0]        llu_data,
  output logic                     llu_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  output logic                     issue_ready,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  output logic                     pipe_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wr_reg,
  output logic [DATA_W-1:0]        rf_wr_data,
  output logic                     waw_err
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W  = $clog2(MAX_OUT + 1);

  typedef enum logic {S_NORM, S_STALL} state_t;

  state_t                  state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]        out_cnt;
  logic [(1<<ADDR_W)-1:0]  busy_nxt;

  logic wb_grant;
  logic llu_hs;
  logic llu_blocked;
  logic sb_set;
  logic sb_clr;
  logic cnt_full;
  logic reg_busy;

  always_comb begin
    wb_grant    = (state == S_NORM) && wb_valid;
    llu_ready   = (state == S_STALL) || !wb_valid;
    llu_hs      = llu_valid && llu_ready;
    llu_blocked = llu_valid && !llu_ready;
    // Only results for tracked destinations retire a scoreboard entry.
    sb_clr      = llu_hs && busy_mask[llu_reg];
    cnt_full    = (out_cnt == CNT_W'(MAX_OUT)) && !sb_clr;
    reg_busy    = busy_mask[issue_reg] && !(sb_clr && (llu_reg == issue_reg));
    issue_ready = (issue_reg == '0) || (!cnt_full && !reg_busy);
    sb_set      = issue_valid && issue_ready && (issue_reg != '0);
  end

  always_comb begin
    busy_nxt = busy_mask;
    if (sb_clr) busy_nxt[llu_reg] = 1'b0;
    if (sb_set) busy_nxt[issue_reg] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_NORM;
      pipe_stall <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_NORM: begin
          if (llu_blocked) begin
            if (wait_cnt == WAIT_W'(STARVE_LIMIT - 1)) begin
              state      <= S_STALL;
              pipe_stall <= 1'b1;
            end
            if (wait_cnt != WAIT_W'(STARVE_LIMIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        S_STALL: begin
          if (llu_hs || !llu_valid) begin
            state      <= S_NORM;
            pipe_stall <= 1'b0;
            wait_cnt   <= '0;
          end
        end
        default: begin
          state      <= S_NORM;
          pipe_stall <= 1'b0;
          wait_cnt   <= '0;
        end
      endcase
    end
  end

  // Register 0 grants still complete their handshake but never assert the write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we      <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end else if (wb_grant) begin
      rf_we      <= (wb_reg != '0);
      rf_wr_reg  <= wb_reg;
      rf_wr_data <= wb_data;
    end else if (llu_hs) begin
      rf_we      <= (llu_reg != '0);
      rf_wr_reg  <= llu_reg;
      rf_wr_data <= llu_data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_mask <= '0;
      out_cnt   <= '0;
    end else begin
      busy_mask <= busy_nxt;
      case ({sb_set, sb_clr})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

`ifdef RF_ARB_WAW_CHECK_EN
  // An older long-latency result would later clobber this in-order write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      waw_err <= 1'b0;
    end else if (wb_grant && (wb_reg != '0) && busy_mask[wb_reg]) begin
      waw_err <= 1'b1;
    end
  end
`else
  assign waw_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written starvation/reset sequences, then random traffic against a reference model.
module tb_rf_write_arbiter;

  localparam int SL = 4;
  localparam int MO = 4;
`ifdef RF_ARB_WAW_CHECK_EN
  localparam logic WAW = 1'b1;
`else
  localparam logic WAW = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        llu_valid = 1'b0;
  logic [4:0]  llu_reg = '0;
  logic [31:0] llu_data = '0;
  logic        llu_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        issue_ready;
  logic [31:0] busy_mask;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic        waw_err;

  int total = 0;
  int bad = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(SL), .MAX_OUT(MO)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_reg(llu_reg), .llu_data(llu_data), .llu_ready(llu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .busy_mask(busy_mask), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .waw_err(waw_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    llu_valid = 1'b0; llu_reg = '0; llu_data = '0;
    issue_valid = 1'b0; issue_reg = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pend;
  logic        m_stalled;
  int          m_blk;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_known;
  logic        m_waw;
  logic        m_acc;

  function automatic int popcount(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic m_llu_rdy();
    return m_stalled ? 1'b1 : !wb_valid;
  endfunction

  function automatic logic m_iss_rdy();
    logic done;
    done = llu_valid && m_llu_rdy() && m_pend[llu_reg];
    if (issue_reg == 5'd0) return 1'b1;
    if (popcount(m_pend) >= MO && !done) return 1'b0;
    if (m_pend[issue_reg] && !(done && llu_reg == issue_reg)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_stalled = 1'b0; m_blk = 0;
    m_we = 1'b0; m_reg = '0; m_data = '0; m_known = 1'b1; m_waw = 1'b0; m_acc = 1'b0;
  endtask

  task automatic model_step();
    logic rdy, gwb, gll, done, iok;
    rdy  = m_llu_rdy();
    iok  = m_iss_rdy();
    gwb  = !m_stalled && wb_valid;
    gll  = llu_valid && rdy;
    done = gll && m_pend[llu_reg];
    if (WAW && gwb && wb_reg != 5'd0 && m_pend[wb_reg]) m_waw = 1'b1;
    m_we = 1'b0;
    if (gwb) begin
      m_we = (wb_reg != 5'd0); m_reg = wb_reg; m_data = wb_data; m_known = (wb_reg != 5'd0);
    end else if (gll) begin
      m_we = (llu_reg != 5'd0); m_reg = llu_reg; m_data = llu_data; m_known = (llu_reg != 5'd0);
    end
    if (done) m_pend[llu_reg] = 1'b0;
    if (issue_valid && iok && issue_reg != 5'd0) m_pend[issue_reg] = 1'b1;
    if (m_stalled) begin
      m_stalled = 1'b0; m_blk = 0;
    end else if (llu_valid && !rdy) begin
      m_blk++;
      if (m_blk >= SL) begin m_stalled = 1'b1; m_blk = 0; end
    end else begin
      m_blk = 0;
    end
    m_acc = gll;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic wv; logic [4:0] wr; logic [31:0] wd;
    logic lv; logic [4:0] lr; logic [31:0] ld;
    logic iv; logic [4:0] ir;
    logic e_lrdy; logic e_irdy; logic e_we; logic e_chk;
    logic [4:0] e_reg; logic [31:0] e_dat; logic [31:0] e_busy; logic e_waw;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd5, 32'h55550002, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0,        32'h0,  1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55550002, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAA0001, 32'h0,  1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h55550002, 32'h0,  1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55550002, 32'h0,  1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55550002, 32'h0,  1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55550002, 32'h80, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55550002, 32'h80, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77,       32'h80, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       32'h80, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       32'h82, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       32'h86, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77,       32'h8E, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 32'h11,       1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       32'h8E, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11,       32'h9C, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       32'h9C, 1'b0};
    tbl[15] = '{1'b1, 5'd0, 32'hDEAD,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       32'h9C, 1'b0};
    tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        32'h9C, 1'b0};
    tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h9C, 1'b0};
    tbl[18] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        32'h9C, 1'b0};
    tbl[19] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44,       32'h9C, WAW};
    tbl[20] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44,       32'h9C, WAW};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_reg", 64'(rf_wr_reg), 64'd0);
    chk("rst_data", 64'(rf_wr_data), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_waw", 64'(waw_err), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      wb_valid = tbl[i].wv; wb_reg = tbl[i].wr; wb_data = tbl[i].wd;
      llu_valid = tbl[i].lv; llu_reg = tbl[i].lr; llu_data = tbl[i].ld;
      issue_valid = tbl[i].iv; issue_reg = tbl[i].ir;
      @(negedge clock);
      chk($sformatf("v%0d_llu_ready", i), 64'(llu_ready), 64'(tbl[i].e_lrdy));
      chk($sformatf("v%0d_issue_ready", i), 64'(issue_ready), 64'(tbl[i].e_irdy));
      chk($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(tbl[i].e_we));
      chk($sformatf("v%0d_busy", i), 64'(busy_mask), 64'(tbl[i].e_busy));
      chk($sformatf("v%0d_stall", i), 64'(pipe_stall), 64'd0);
      chk($sformatf("v%0d_waw", i), 64'(waw_err), 64'(tbl[i].e_waw));
      if (tbl[i].e_chk) begin
        chk($sformatf("v%0d_wr_reg", i), 64'(rf_wr_reg), 64'(tbl[i].e_reg));
        chk($sformatf("v%0d_wr_data", i), 64'(rf_wr_data), 64'(tbl[i].e_dat));
      end
      nxt();
    end

    // Starvation: WB hogs the port, result for reg 8 is forced through on cycle 4.
    do_reset();
    issue_valid = 1'b1; issue_reg = 5'd8;
    @(negedge clock); chk("st_issue", 64'(issue_ready), 64'd1); nxt();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h1111;
    llu_valid = 1'b1; llu_reg = 5'd8; llu_data = 32'h8888;
    for (int c = 0; c < SL; c++) begin
      @(negedge clock);
      chk($sformatf("st_c%0d_ready", c), 64'(llu_ready), 64'd0);
      chk($sformatf("st_c%0d_stall", c), 64'(pipe_stall), 64'd0);
      nxt();
    end
    @(negedge clock);
    chk("st_stall_on", 64'(pipe_stall), 64'd1);
    chk("st_stall_ready", 64'(llu_ready), 64'd1);
    chk("st_busy", 64'(busy_mask), 64'h100);
    nxt();
    llu_valid = 1'b0;
    @(negedge clock);
    chk("st_we", 64'(rf_we), 64'd1);
    chk("st_reg", 64'(rf_wr_reg), 64'd8);
    chk("st_data", 64'(rf_wr_data), 64'h8888);
    chk("st_stall_off", 64'(pipe_stall), 64'd0);
    chk("st_busy_clr", 64'(busy_mask), 64'd0);
    chk("st_wb_prio", 64'(llu_ready), 64'd0);
    nxt();

    // Reset asserted while stalled with reg 8 pending.
    issue_valid = 1'b1; issue_reg = 5'd8;
    @(negedge clock); chk("rm_issue", 64'(issue_ready), 64'd1); nxt();
    issue_valid = 1'b0; llu_valid = 1'b1;
    repeat (SL) nxt();
    @(negedge clock);
    chk("rm_stall", 64'(pipe_stall), 64'd1);
    chk("rm_busy", 64'(busy_mask), 64'h100);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_we", 64'(rf_we), 64'd0);
    chk("rm_reg", 64'(rf_wr_reg), 64'd0);
    chk("rm_data", 64'(rf_wr_data), 64'd0);
    chk("rm_stall0", 64'(pipe_stall), 64'd0);
    chk("rm_busy0", 64'(busy_mask), 64'd0);
    chk("rm_waw0", 64'(waw_err), 64'd0);
    idle_inputs();
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_reg   = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      if (llu_valid && (m_acc || $urandom_range(0, 15) == 0)) llu_valid = 1'b0;
      if (!llu_valid && m_pend != '0 && $urandom_range(0, 2) == 0) begin
        logic [4:0] q[$];
        for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(5'(r));
        llu_valid = 1'b1;
        llu_reg   = q[$urandom_range(0, q.size() - 1)];
        llu_data  = $urandom;
      end
      issue_valid = $urandom_range(0, 1) != 0;
      issue_reg   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      @(negedge clock);
      chk("r_llu_ready", 64'(llu_ready), 64'(m_llu_rdy()));
      chk("r_issue_ready", 64'(issue_ready), 64'(m_iss_rdy()));
      chk("r_rf_we", 64'(rf_we), 64'(m_we));
      chk("r_busy", 64'(busy_mask), 64'(m_pend));
      chk("r_stall", 64'(pipe_stall), 64'(m_stalled));
      chk("r_waw", 64'(waw_err), 64'(m_waw));
      if (m_known) begin
        chk("r_wr_reg", 64'(rf_wr_reg), 64'(m_reg));
        chk("r_wr_data", 64'(rf_wr_data), 64'(m_data));
      end
      model_step();
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
